airi5c_uart_tx_arbiter: RTL and testbench
=========================================

# airi5c_uart_tx_arbiter

Shares the single 9-bit push port of the UART transmitter FIFO among up to eight requesters, such as the CPU bus slave, the DMA engine and the debug console. Requesters present frames as valid/ready streams with an end-of-frame marker. The arbiter grants one requester at a time in round-robin order and locks the grant for a whole frame, so bytes from different sources never interleave on the line. It sits between the requesters and the transmitter's `push`/`data_in`/`full` ports.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `MAX_BURST`, 16: maximum beats per grant when the burst limit is compiled in; legal range 1..256.
- `clk` input 1: clock, rising edge.
- `n_reset` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous flush of arbitration state.
- `valid` input NUM_REQ: bit i means requester i presents a beat.
- `last` input NUM_REQ: bit i marks requester i's current beat as the end of its frame.
- `data` input 9*NUM_REQ: beat data; requester i uses bits [9i+8:9i].
- `ready` output NUM_REQ: bit i means requester i's beat is accepted this cycle if `valid[i]` is high.
- `fifo_full` input 1: transmitter FIFO full.
- `push` output 1: write strobe to the transmitter FIFO.
- `push_data` output 9: data to the transmitter FIFO.
- `owner` output 3: index of the current grant holder.
- `busy` output 1: a grant is held.

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - If any `valid` bit is set, select the first set bit searching from `(prev+1) mod NUM_REQ` upward with wrap-around.
  - Load `owner` with that index, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `ready[owner] = !fifo_full && !clear`. All other `ready` bits are 0.
  - `push = valid[owner] && ready[owner]`. `push_data` is the owner's data slice.
  - On an accepted beat, `beat_cnt` increments; `beat_cnt` is `$clog2(MAX_BURST)+1` bits wide and saturates.
  - Release condition: an accepted beat with `last[owner]` set, or the burst limit being hit (see Configuration).
  - On release: `prev <= owner`, go to IDLE.
- Lock: if the owner drops `valid` mid-frame, the grant is held and nothing is pushed. No timeout.
- `fifo_full` stalls the owner: no push, counter unchanged, grant kept.
- `clear`: next state IDLE, `prev <= NUM_REQ-1`, `beat_cnt <= 0`, `owner <= 0`. `ready` and `push` are forced to 0 in the same cycle.
- Reset values: state IDLE, `prev = NUM_REQ-1` so requester 0 has first priority, `owner = 0`, `beat_cnt = 0`. Outputs `ready = 0`, `push = 0`, `push_data = 0`, `busy = 0`.
- `busy` is high exactly in GRANT (registered state decode).
- `valid` bits with index ≥ NUM_REQ do not exist. `owner` upper bits are 0 when NUM_REQ < 8.

## Timing
- `ready`, `push` and `push_data` are combinational from registered state, `valid`, `fifo_full` and `clear`. There is no combinational path from `valid` to `ready`.
- Grant latency: `valid` seen in IDLE in cycle N gives `ready` in cycle N+1.
- Release: the last beat is accepted in cycle N, the arbiter is in IDLE in cycle N+1, and the next grant's `ready` appears in cycle N+2. This gives exactly one dead cycle between frames.
- Sustained throughput is one beat per cycle within a frame while `!fifo_full`.
- When a single requester always has `valid` high, it is re-granted after each release, still with one dead cycle.
- `fifo_full` may toggle every cycle. Each low cycle with owner `valid` high pushes exactly one beat.
- Asynchronous reset mid-frame abandons the frame. Partially pushed beats stay in the FIFO.

## Configuration
- `AIRI5C_UART_TX_ARB_BURST_LIMIT_EN` defined:
  - Release also occurs on the accepted beat that brings `beat_cnt` to MAX_BURST, even without `last`.
  - The frame then continues at the requester's next grant, so frames longer than MAX_BURST interleave.
- `AIRI5C_UART_TX_ARB_BURST_LIMIT_EN` undefined:
  - Only `last` releases the grant.
  - `beat_cnt` logic and the MAX_BURST check are absent.

## Test plan
- Reset, then `valid = 4'b1010`, `fifo_full = 0`:
  - `owner = 1` and `ready = 4'b0010` one cycle later.
  - After requester 1's `last` beat, one dead cycle, then `owner = 3`.
- All four requesters valid, each sending 2-beat frames (data `0x100+i`, `0x0i`):
  - Grant order 0,1,2,3,0.
  - `push` pattern is 2 beats then 1 idle cycle, with no interleaving.
- Owner drops `valid` for 5 cycles mid-frame while requester 2 is valid:
  - `owner` is unchanged, `push = 0`, `ready[2] = 0` throughout.
- `fifo_full` high for 3 cycles during a 4-beat frame:
  - `push` low in exactly those 3 cycles.
  - All 4 bytes arrive in order, and `beat_cnt` ends at 4.
- With the macro defined and `MAX_BURST = 4`, requesters 0 and 1 each stream 10 beats:
  - Output order is 4×r0, 4×r1, 4×r0, 4×r1, 2×r0, 2×r1.
  - Without the macro, the order is 10×r0, 10×r1.
- `clear` asserted mid-frame of `owner = 2`:
  - `ready = 0` and `push = 0` in that cycle, IDLE next cycle.
  - With all requesters valid, the next grant goes to requester 0.

Source files
------------

// File: rtl/airi5c_uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing the UART TX FIFO push port among NUM_REQ requesters.
// Optional per-grant burst limit: define AIRI5C_UART_TX_ARB_BURST_LIMIT_EN.
module airi5c_uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 clear,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [9*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ready,
  input  logic                 fifo_full,
  output logic                 push,
  output logic [8:0]           push_data,
  output logic [2:0]           owner,
  output logic                 busy
);

  // state | meaning
  // IDLE  | no grant held; pick next requester round-robin after prev
  // GRANT | owner holds the port until its frame ends (or burst limit)
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [2:0] PREV_RST = 3'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..256");
  end

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] prev_q, prev_d;

  logic       own_valid, own_last;
  logic [8:0] own_data;
  logic       sel_found;
  logic [2:0] sel_idx;
  logic       accept, release_grant;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_valid = valid[i];
        own_last  = last[i];
        own_data  = data[9*i +: 9];
      end
    end
  end

  // Search starts just after the previous owner, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(prev_q) + k) % NUM_REQ;
      if (!sel_found && valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(idx);
      end
    end
  end

`ifdef AIRI5C_UART_TX_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] beat_cnt;
  logic             burst_hit;

  assign burst_hit = accept && (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      beat_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (state_q == IDLE && sel_found) begin
      beat_cnt <= '0;
    end else if (accept && beat_cnt != '1) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign release_grant = accept && (own_last || burst_hit);
`else
  assign release_grant = accept && own_last;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prev_d    = prev_q;
    ready     = '0;
    push      = 1'b0;
    push_data = '0;
    accept    = 1'b0;

    if (state_q == GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == 3'(i)) ready[i] = !fifo_full && !clear;
      end
      accept    = own_valid && !fifo_full && !clear;
      push      = accept;
      push_data = own_data;
    end

    if (clear) begin
      state_d = IDLE;
      prev_d  = PREV_RST;
      owner_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_d = GRANT;
            owner_d = sel_idx;
          end
        end
        GRANT: begin
          if (release_grant) begin
            prev_d  = owner_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      prev_q  <= PREV_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prev_q  <= prev_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_airi5c_uart_tx_arbiter.sv
// Randomized bench for airi5c_uart_tx_arbiter: a grant-level reference model predicts ready/push/owner
// each cycle and queues expected FIFO bytes; a separate monitor pops them as the DUT pushes.
module tb_airi5c_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
`ifdef AIRI5C_UART_TX_ARB_BURST_LIMIT_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         clear = 1'b0;
  logic         fifo_full = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N-1:0] last = '0;
  logic [9*N-1:0] data = '0;
  logic [N-1:0] ready;
  logic         push;
  logic [8:0]   push_data;
  logic [2:0]   owner;
  logic         busy;

  airi5c_uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .n_reset(n_reset), .clear(clear), .valid(valid), .last(last),
    .data(data), .ready(ready), .fifo_full(fifo_full), .push(push),
    .push_data(push_data), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the port, who held it last, beats in this grant.
  int         m_holder = -1;
  int         m_prev   = N - 1;
  int         m_owner  = 0;
  int         m_cnt    = 0;
  logic [8:0] exp_q[$];
  logic [N-1:0] acc = '0;
  bit         model_on = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] er;
    logic ep;
    int idx;
    if (model_on) begin
      er = '0;
      ep = 1'b0;
      if (m_holder >= 0) begin
        er[m_holder] = !fifo_full && !clear;
        ep = er[m_holder] && valid[m_holder];
      end
      check("ready", 32'(ready), 32'(er));
      check("push", 32'(push), 32'(ep));
      check("busy", 32'(busy), 32'(m_holder >= 0));
      check("owner", 32'(owner), 32'(m_owner));
      if (ep) exp_q.push_back(data[9*m_holder +: 9]);
      acc = valid & ready;

      if (clear) begin
        m_holder = -1; m_prev = N - 1; m_owner = 0; m_cnt = 0;
      end else if (m_holder < 0) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_prev + k) % N;
          if (m_holder < 0 && valid[idx]) begin
            m_holder = idx; m_owner = idx; m_cnt = 0;
          end
        end
      end else if (ep) begin
        m_cnt++;
        if (last[m_holder] || (BL && m_cnt == MB)) begin
          m_prev = m_holder; m_holder = -1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    #1;
    if (model_on && push === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_push", 32'(push_data), 32'h1ff + 1);
      end else begin
        check("push_data", 32'(push_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Requester stream generators.
  int         frames_left[N];
  int         len[N];
  int         pos[N];
  logic [8:0] cur[N];
  int         dens  = 100;
  int         fullp = 0;
  int         clrp  = 0;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          pos[i] = 0;
          len[i] = $urandom_range(1, 20);
          frames_left[i]--;
        end
        cur[i] = 9'($urandom_range(0, 511));
      end
      valid[i] = (frames_left[i] > 0) && ($urandom_range(0, 99) < dens);
      last[i]  = (pos[i] == len[i] - 1);
      data[9*i +: 9] = cur[i];
    end
    fifo_full = ($urandom_range(0, 99) < fullp);
    clear     = ($urandom_range(0, 999) < clrp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_phase(input int d, input int fp, input int cp, input int frames, input int cycles);
    dens = d; fullp = fp; clrp = cp;
    for (int i = 0; i < N; i++) frames_left[i] += frames;
    repeat (cycles) step();
  endtask

  int budget;
  bit pending;

  initial begin
    for (int i = 0; i < N; i++) begin
      frames_left[i] = 0;
      len[i] = $urandom_range(1, 20);
      pos[i] = 0;
      cur[i] = 9'($urandom_range(0, 511));
    end

    valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_push", 32'(push), 32'(0));
    check("rst_push_data", 32'(push_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    valid = '0;

    @(posedge clk);
    #1;
    n_reset = 1'b1;
    model_on = 1'b1;
    // Requesters 1 and 3 first, so the first search from prev=N-1 must skip index 0.
    frames_left[1] = 2;
    frames_left[3] = 2;
    drive_inputs();
    repeat (80) step();

    run_phase(100, 0, 0, 3, 400);
    run_phase(70, 30, 0, 3, 800);
    run_phase(40, 60, 5, 3, 1200);
    run_phase(90, 50, 2, 3, 1000);

    dens = 100; fullp = 0; clrp = 0;
    budget = 0;
    pending = 1'b1;
    while (pending && budget < 20000) begin
      step();
      budget++;
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (frames_left[i] > 0) pending = 1'b1;
    end
    check("drain_timeout", 32'(pending), 32'(0));
    repeat (5) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
